alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-requester front end for one shared, pipelined ALU. Only one operation
//   is in flight at a time. The grant alternates when both requesters ask in
//   the same cycle. Illegal operations are answered with an error and never
//   reach the ALU. The ALU result is returned through a valid/ready response
//   port.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqN_valid / reqN_ready       request handshake (ready is a 1-cycle accept pulse)
//   reqN_a, reqN_b, reqN_op       3-bit operands and opcode (000 AND, 001 XOR, 010 ADD, 011 MUL)
//   reqN_cin, reqN_red_a/_b       carry-in and operand reduction selects
//   alu_*                         shared ALU drive, non-zero only during ISSUE
//   alu_out                       ALU registered result, valid ALU_LAT cycles after ISSUE
//   rsp_valid / rsp_ready         response handshake
//   rsp_id, rsp_data, rsp_err     owner, result and rejection flag
module alu_arbiter #(
  parameter int ALU_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_a,
  input  logic [2:0] req0_b,
  input  logic [2:0] req0_op,
  input  logic       req0_cin,
  input  logic       req0_red_a,
  input  logic       req0_red_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_a,
  input  logic [2:0] req1_b,
  input  logic [2:0] req1_op,
  input  logic       req1_cin,
  input  logic       req1_red_a,
  input  logic       req1_red_b,
  output logic [2:0] alu_a,
  output logic [2:0] alu_b,
  output logic [2:0] alu_opcode,
  output logic       alu_cin,
  output logic       alu_red_a,
  output logic       alu_red_b,
  output logic       alu_serial_in,
  output logic       alu_direction,
  output logic       alu_bypass_a,
  output logic       alu_bypass_b,
  input  logic [5:0] alu_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [5:0] rsp_data,
  output logic       rsp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [2:0] LAST_CNT = 3'(ALU_LAT - 1);

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [2:0] cnt_q, cnt_d;

  logic [2:0] a_q, b_q, op_q;
  logic       cin_q, red_a_q, red_b_q, id_q;
  logic [5:0] rsp_data_q;
  logic       rsp_err_q;

  logic       sel;
  logic [2:0] sel_a, sel_b, sel_op;
  logic       sel_cin, sel_red_a, sel_red_b;
  logic       accept, illegal, wait_done;

  // Tie: the requester not granted last wins; otherwise whoever is valid.
  assign sel       = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign sel_a     = sel ? req1_a     : req0_a;
  assign sel_b     = sel ? req1_b     : req0_b;
  assign sel_op    = sel ? req1_op    : req0_op;
  assign sel_cin   = sel ? req1_cin   : req0_cin;
  assign sel_red_a = sel ? req1_red_a : req0_red_a;
  assign sel_red_b = sel ? req1_red_b : req0_red_b;

  assign accept    = (state_q == IDLE) && (req0_valid || req1_valid);
  // Opcodes 1xx are undefined; ADD/MUL have no reduced-operand form.
  assign illegal   = sel_op[2] || (sel_op[1] && (sel_red_a || sel_red_b));
  assign wait_done = (state_q == WAIT) && (cnt_q == LAST_CNT);

  // State register (control only)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= 3'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          last_grant_d = sel;
          state_d      = illegal ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 3'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_done) begin
          cnt_d   = 3'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Payload registers: outputs are gated by state, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q     <= sel_a;
      b_q     <= sel_b;
      op_q    <= sel_op;
      cin_q   <= sel_cin;
      red_a_q <= sel_red_a;
      red_b_q <= sel_red_b;
      id_q    <= sel;
      if (illegal) begin
        rsp_data_q <= 6'd0;
        rsp_err_q  <= 1'b1;
      end
    end
    if (wait_done) begin
      rsp_data_q <= alu_out;
      rsp_err_q  <= 1'b0;
    end
  end

  // Output logic
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_a      = 3'd0;
    alu_b      = 3'd0;
    alu_opcode = 3'd0;
    alu_cin    = 1'b0;
    alu_red_a  = 1'b0;
    alu_red_b  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_id     = 1'b0;
    rsp_data   = 6'd0;
    rsp_err    = 1'b0;
    // State sits in IDLE during reset; rst_n keeps the accept pulse quiet then.
    if (accept && rst_n) begin
      req0_ready = ~sel;
      req1_ready = sel;
    end
    if (state_q == ISSUE) begin
      alu_a      = a_q;
      alu_b      = b_q;
      alu_opcode = op_q;
      alu_cin    = cin_q;
      alu_red_a  = red_a_q;
      alu_red_b  = red_b_q;
    end
    if (state_q == RESP) begin
      rsp_valid = 1'b1;
      rsp_id    = id_q;
      rsp_data  = rsp_data_q;
      rsp_err   = rsp_err_q;
    end
  end

  assign alu_serial_in = 1'b0;
  assign alu_direction = 1'b0;
  assign alu_bypass_a  = 1'b0;
  assign alu_bypass_b  = 1'b0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural shared ALU of latency LAT.
module tb_alu_arbiter;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_cin, req0_red_a, req0_red_b;
  logic [2:0] req0_a, req0_b, req0_op;
  logic       req1_valid, req1_ready, req1_cin, req1_red_a, req1_red_b;
  logic [2:0] req1_a, req1_b, req1_op;
  logic [2:0] alu_a, alu_b, alu_opcode;
  logic       alu_cin, alu_red_a, alu_red_b;
  logic       alu_serial_in, alu_direction, alu_bypass_a, alu_bypass_b;
  logic [5:0] alu_out;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [5:0] rsp_data;

  int n_chk;
  int n_fail;
  int cyc;
  int act;
  int seen;

  always #5 clk = ~clk;

  alu_arbiter #(.ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_cin(req0_cin), .req0_red_a(req0_red_a), .req0_red_b(req0_red_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_cin(req1_cin), .req1_red_a(req1_red_a), .req1_red_b(req1_red_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
    .alu_red_a(alu_red_a), .alu_red_b(alu_red_b), .alu_serial_in(alu_serial_in),
    .alu_direction(alu_direction), .alu_bypass_a(alu_bypass_a), .alu_bypass_b(alu_bypass_b),
    .alu_out(alu_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  // Behavioural shared ALU: samples its inputs every edge, result after LAT edges.
  function automatic logic [5:0] alu_f(input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] op, input logic cin,
                                       input logic ra, input logic rb);
    logic [5:0] x, y;
    x = ra ? {5'd0, &a} : {3'd0, a};
    y = rb ? {5'd0, &b} : {3'd0, b};
    case (op)
      3'd0:    return x & y;
      3'd1:    return x ^ y;
      3'd2:    return x + y + {5'd0, cin};
      3'd3:    return x * y;
      default: return 6'd0;
    endcase
  endfunction

  logic [5:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= alu_f(alu_a, alu_b, alu_opcode, alu_cin, alu_red_a, alu_red_b);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign alu_out = pipe[LAT-1];

  logic alu_any;
  assign alu_any = |{alu_a, alu_b, alu_opcode, alu_cin, alu_red_a, alu_red_b,
                     alu_serial_in, alu_direction, alu_bypass_a, alu_bypass_b};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called in the cycle after accept; returns the accept-relative cycle of the
  // first rsp_valid and the number of cycles the ALU was driven meanwhile.
  task automatic wait_rsp(output int c, output int a);
    c = 1;
    a = 0;
    while (!rsp_valid && c < 20) begin
      if (alu_any) a++;
      tick();
      c++;
    end
  endtask

  task automatic set_req0(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                          input logic cin, input logic ra, input logic rb);
    req0_op = op; req0_a = a; req0_b = b; req0_cin = cin; req0_red_a = ra; req0_red_b = rb;
  endtask

  task automatic set_req1(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                          input logic cin, input logic ra, input logic rb);
    req1_op = op; req1_a = a; req1_b = b; req1_cin = cin; req1_red_a = ra; req1_red_b = rb;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req1_valid = 1'b0;
    set_req0(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    set_req1(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    req0_valid = 1'b1;
    repeat (3) tick();

    // Reset: everything quiet even with a request pending
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_alu_any", alu_any, 0);

    // ADD 7+7+1, accepted in the first cycle after reset release
    set_req0(3'd2, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("t1_req0_ready", req0_ready, 1);
    chk("t1_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("t1_alu_opcode", alu_opcode, 2);
    chk("t1_alu_a", alu_a, 7);
    chk("t1_alu_cin", alu_cin, 1);
    chk("t1_ties", {alu_serial_in, alu_direction, alu_bypass_a, alu_bypass_b}, 0);
    chk("t1_ready_issue", req0_ready, 0);
    wait_rsp(cyc, act);
    chk("t1_latency", cyc, 4);
    chk("t1_alu_cycles", act, 1);
    chk("t1_data", rsp_data, 15);
    chk("t1_id", rsp_id, 0);
    chk("t1_err", rsp_err, 0);
    tick();
    chk("t1_idle_after", rsp_valid, 0);

    // Tie after reset: req0 wins, req1 waits for the first handshake
    rst_n = 1'b0;
    tick();
    set_req0(3'd3, 3'd3, 3'd5, 1'b0, 1'b0, 1'b0);
    set_req1(3'd1, 3'd6, 3'd3, 1'b0, 1'b0, 1'b0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("t2_req0_ready", req0_ready, 1);
    chk("t2_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("t2_req1_ready_issue", req1_ready, 0);
    wait_rsp(cyc, act);
    chk("t2_latency0", cyc, 4);
    chk("t2_data0", rsp_data, 15);
    chk("t2_id0", rsp_id, 0);
    chk("t2_req1_ready_resp", req1_ready, 0);
    tick();
    chk("t2_req1_accept", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    #1;
    wait_rsp(cyc, act);
    chk("t2_latency1", cyc, 4);
    chk("t2_data1", rsp_data, 5);
    chk("t2_id1", rsp_id, 1);
    tick();

    // Illegal: opcode 100
    set_req1(3'd4, 3'd5, 3'd3, 1'b0, 1'b0, 1'b0);
    req1_valid = 1'b1;
    #1;
    chk("t3a_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    #1;
    wait_rsp(cyc, act);
    chk("t3a_latency", cyc, 1);
    chk("t3a_alu_cycles", act, 0);
    chk("t3a_err", rsp_err, 1);
    chk("t3a_data", rsp_data, 0);
    chk("t3a_id", rsp_id, 1);
    tick();
    chk("t3a_idle_after", rsp_valid, 0);

    // Illegal: ADD with reduced A
    set_req1(3'd2, 3'd3, 3'd4, 1'b0, 1'b1, 1'b0);
    req1_valid = 1'b1;
    #1;
    chk("t3b_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    #1;
    wait_rsp(cyc, act);
    chk("t3b_latency", cyc, 1);
    chk("t3b_alu_cycles", act, 0);
    chk("t3b_err", rsp_err, 1);
    chk("t3b_data", rsp_data, 0);
    tick();

    // AND with reduced B: 7 & (&7)=1
    set_req0(3'd0, 3'd7, 3'd7, 1'b0, 1'b0, 1'b1);
    req0_valid = 1'b1;
    #1;
    chk("t4a_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    #1;
    wait_rsp(cyc, act);
    chk("t4a_latency", cyc, 4);
    chk("t4a_data", rsp_data, 1);
    chk("t4a_err", rsp_err, 0);
    tick();

    // AND with both reduced: (&6)=0 & (&7)=1 -> 0
    set_req0(3'd0, 3'd6, 3'd7, 1'b0, 1'b1, 1'b1);
    req0_valid = 1'b1;
    #1;
    chk("t4b_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    #1;
    wait_rsp(cyc, act);
    chk("t4b_latency", cyc, 4);
    chk("t4b_alu_cycles", act, 1);
    chk("t4b_data", rsp_data, 0);
    tick();

    // Back-pressure: XOR 5^1=4 held in RESP while req1 (ADD 2+3+1=6) waits
    rsp_ready = 1'b0;
    set_req0(3'd1, 3'd5, 3'd1, 1'b0, 1'b0, 1'b0);
    req0_valid = 1'b1;
    #1;
    chk("t5_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    set_req1(3'd2, 3'd2, 3'd3, 1'b1, 1'b0, 1'b0);
    req1_valid = 1'b1;
    #1;
    wait_rsp(cyc, act);
    chk("t5_latency0", cyc, 4);
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", rsp_valid, 1);
      chk("t5_hold_id", rsp_id, 0);
      chk("t5_hold_data", rsp_data, 4);
      chk("t5_hold_req1_ready", req1_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("t5_valid_at_hs", rsp_valid, 1);
    chk("t5_req1_ready_at_hs", req1_ready, 0);
    tick();
    chk("t5_req1_accept", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    #1;
    wait_rsp(cyc, act);
    chk("t5_latency1", cyc, 4);
    chk("t5_data1", rsp_data, 6);
    chk("t5_id1", rsp_id, 1);
    tick();

    // Reset in the second WAIT cycle drops the operation
    set_req0(3'd3, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0);
    req0_valid = 1'b1;
    #1;
    chk("t6_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", rsp_valid, 0);
    chk("t6_rst_alu", alu_any, 0);
    chk("t6_rst_data", rsp_data, 0);
    chk("t6_rst_ready", {req0_ready, req1_ready}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen++;
      tick();
    end
    chk("t6_no_rsp", seen, 0);
    set_req0(3'd2, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0);
    req0_valid = 1'b1;
    #1;
    chk("t6_fresh_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    #1;
    wait_rsp(cyc, act);
    chk("t6_latency", cyc, 4);
    chk("t6_data", rsp_data, 3);
    chk("t6_id", rsp_id, 0);
    chk("t6_err", rsp_err, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
